// File: rtl/updown_count_scheduler.sv
// updown_count_scheduler
//
// Shares one mod-(MAX_VAL+1) up/down counter between two requesters.
// Each requester asks for a run of N steps in a chosen direction. The block
// arbitrates round-robin in IDLE, steps the counter once per cycle in RUN,
// and pulses done for one cycle in DONE. The counter value is kept between
// jobs; only reset returns it to 0.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous, active-high reset
//   req[1:0]    in   per-requester request
//   req_mode    in   per-requester direction (1 = up, 0 = down), sampled at grant
//   req_steps0  in   requester 0 step count, sampled at grant
//   req_steps1  in   requester 1 step count, sampled at grant
//   grant[1:0]  out  one-hot owner of the counter, 00 when idle
//   owner       out  index of the current or last granted requester
//   busy        out  high while in RUN or DONE
//   done        out  one-cycle completion pulse of a granted job
//   cnt_out     out  counter value, always within 0..MAX_VAL
//   state_dbg   out  current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Handshake: a requester raises req[i] and holds it high until it sees done
// with grant[i] set, or until it chooses to abort. Dropping req[owner] while
// the job is in RUN aborts it on the next edge without a done pulse.
// Requests are sampled only in IDLE; mode and steps only at the grant edge.

module updown_count_scheduler #(
  parameter int unsigned MAX_VAL = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] req_mode,
  input  logic [3:0] req_steps0,
  input  logic [3:0] req_steps1,
  output logic [1:0] grant,
  output logic       owner,
  output logic       busy,
  output logic       done,
  output logic [3:0] cnt_out,
  output logic [1:0] state_dbg
);

  localparam logic [3:0] MAX_V = 4'(MAX_VAL);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] rem_q, rem_d;
  logic       dir_q, dir_d;
  logic [1:0] grant_q, grant_d;
  logic       owner_q, owner_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       rr_q, rr_d;

  logic       win;
  logic [3:0] win_steps;

  // One wrapping step of the counter in the given direction.
  function automatic logic [3:0] step_cnt(input logic [3:0] c, input logic up);
    logic [3:0] r;
    if (up) r = (c == MAX_V) ? 4'd0 : c + 4'd1;
    else    r = (c == 4'd0)  ? MAX_V : c - 4'd1;
    return r;
  endfunction

  // Winner when arbitrating: a lone requester wins, otherwise rr_q decides.
  always_comb begin
    win = 1'b0;
    if (req == 2'b11) win = rr_q;
    else              win = req[1];
    win_steps = win ? req_steps1 : req_steps0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    grant_d = grant_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rr_d    = rr_q;

    unique case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          dir_d   = req_mode[win];
          rem_d   = win_steps;
          grant_d = win ? 2'b10 : 2'b01;
          owner_d = win;
          rr_d    = ~win;
          busy_d  = 1'b1;
          // A zero-step job goes straight to its completion cycle.
          if (win_steps == 4'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (req[owner_q]) begin
          cnt_d = step_cnt(cnt_q, dir_q);
          rem_d = rem_q - 4'd1;
          if (rem_q == 4'd1) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          // Abort: the counter keeps the value already reached.
          state_d = S_IDLE;
          grant_d = 2'b00;
          busy_d  = 1'b0;
          rem_d   = 4'd0;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rem_q   <= 4'd0;
      dir_q   <= 1'b0;
      grant_q <= 2'b00;
      owner_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rr_q    <= rr_d;
    end
  end

  assign grant     = grant_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cnt_out   = cnt_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_updown_count_scheduler.sv
// Testbench for updown_count_scheduler.
// Driver tasks issue jobs and push the expected completion record into
// exp_q; a negedge monitor pops a record whenever done is seen. The model
// works with plain modular arithmetic on integers and an rr pointer that
// simply flips to the other requester after every grant.

module tb_updown_count_scheduler;

  localparam int MAX_VAL = 8;
  localparam int M1      = MAX_VAL + 1;
  localparam int W       = 11; // {grant[1:0], owner, final_cnt[3:0], steps[3:0]}

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [1:0] req_mode;
  logic [3:0] req_steps0;
  logic [3:0] req_steps1;
  logic [1:0] grant;
  logic       owner;
  logic       busy;
  logic       done;
  logic [3:0] cnt_out;
  logic [1:0] state_dbg;

  updown_count_scheduler #(.MAX_VAL(MAX_VAL)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_mode   (req_mode),
    .req_steps0 (req_steps0),
    .req_steps1 (req_steps1),
    .grant      (grant),
    .owner      (owner),
    .busy       (busy),
    .done       (done),
    .cnt_out    (cnt_out),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;

  int model_cnt = 0;
  int model_rr  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [1:0] prev_grant = 2'b00;
  int         grant_cyc  = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_grant = 2'b00;
    end else begin
      chk("grant_onehot", int'(grant == 2'b11), 0);
      chk("busy_vs_grant", int'(busy), int'(grant != 2'b00));
      chk("cnt_range", int'(cnt_out <= 4'(MAX_VAL)), 1);
      if (grant != 2'b00 && prev_grant == 2'b00) grant_cyc = cyc;
      if (done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending job (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("done_grant", int'(grant), int'(e[10:9]));
          chk("done_owner", int'(owner), int'(e[8]));
          chk("done_cnt", int'(cnt_out), int'(e[7:4]));
          chk("done_latency", cyc - grant_cyc, int'(e[3:0]));
        end
      end
      prev_grant = grant;
    end
  end

  // ---------------- model helpers ----------------
  function automatic int pick();
    if (req == 2'b11) return model_rr;
    return req[1] ? 1 : 0;
  endfunction

  // Runs the job of requester w, whose req is already high and whose grant
  // lands on the next rising edge. abort_after < 0 means run to completion,
  // otherwise req is dropped after that many steps.
  task automatic serve(input int w, input int abort_after);
    int           n;
    logic         up;
    logic [1:0]   g;
    int           fin;
    logic [W-1:0] ent;
    logic [31:0]  wv;
    n  = (w == 1) ? int'(req_steps1) : int'(req_steps0);
    up = req_mode[w];
    g  = (w == 1) ? 2'b10 : 2'b01;
    wv = w;
    model_rr = 1 - w;
    if (abort_after < 0) begin
      fin = up ? (model_cnt + n) % M1 : (model_cnt + 2 * M1 - n) % M1;
      ent = {g, wv[0], 4'(fin), 4'(n)};
      exp_q.push_back(ent);
    end
    @(negedge clk);
    chk("grant", int'(grant), int'(g));
    chk("owner", int'(owner), w);
    for (int i = 0; i < n; i++) begin
      if (i == abort_after) begin
        req[w] = 1'b0;
        @(negedge clk);
        chk("abort_grant", int'(grant), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_cnt", int'(cnt_out), model_cnt);
        return;
      end
      @(negedge clk);
      model_cnt = up ? (model_cnt + 1) % M1 : (model_cnt + M1 - 1) % M1;
      chk("step_cnt", int'(cnt_out), model_cnt);
    end
    chk("done_seen", int'(done), 1);
    req[w] = 1'b0;
    @(negedge clk);
    chk("grant_release", int'(grant), 0);
    chk("done_release", int'(done), 0);
  endtask

  task automatic set_job(input int who, input logic up, input int n);
    req_mode[who] = up;
    if (who == 1) req_steps1 = 4'(n);
    else          req_steps0 = 4'(n);
    req[who] = 1'b1;
  endtask

  task automatic one(input int who, input logic up, input int n);
    set_job(who, up, n);
    serve(pick(), -1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_cnt = 0;
    model_rr  = 0;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst        = 1'b1;
    req        = 2'b00;
    req_mode   = 2'b00;
    req_steps0 = 4'd0;
    req_steps1 = 4'd0;
    do_reset();

    chk("reset_cnt", int'(cnt_out), 0);
    chk("reset_grant", int'(grant), 0);
    chk("reset_owner", int'(owner), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_state", int'(state_dbg), 0);

    // Both requesters keep re-requesting: grants alternate 01,10,01,10.
    for (int k = 0; k < 4; k++) begin
      req_mode   = 2'($urandom_range(0, 3));
      req_steps0 = 4'($urandom_range(0, 5));
      req_steps1 = 4'($urandom_range(0, 5));
      req        = 2'b11;
      chk("alt_pick_grant_next", pick(), k % 2);
      serve(pick(), -1);
    end
    req = 2'b00;

    do_reset();
    // Requester 0 up by 3 from reset.
    one(0, 1'b1, 3);
    chk("tp_up3_final", int'(cnt_out), 3);
    // Bring counter to 0, then requester 1 down by 2: 8, 7.
    one(0, 1'b1, 6);
    chk("tp_back_to_zero", int'(cnt_out), 0);
    one(1, 1'b0, 2);
    chk("tp_down2_final", int'(cnt_out), 7);
    chk("tp_owner1", int'(owner), 1);
    // Up wrap: from 5, up by 10, ends at 6.
    one(0, 1'b0, 2);
    chk("tp_at5", int'(cnt_out), 5);
    one(0, 1'b1, 10);
    chk("tp_wrap_final", int'(cnt_out), 6);
    // Zero-step job leaves the counter alone.
    one(1, 1'b1, 0);
    chk("tp_zero_step_cnt", int'(cnt_out), 6);
    // Abort: counter to 0, point rr at requester 0, then both request.
    one(0, 1'b1, 3);
    one(1, 1'b1, 0);
    req_mode   = 2'b01;
    req_steps0 = 4'd6;
    req_steps1 = 4'd4;
    req        = 2'b11;
    serve(pick(), 2);
    chk("tp_abort_cnt", int'(cnt_out), 2);
    serve(pick(), -1);
    chk("tp_pending_owner", int'(owner), 1);
    chk("tp_pending_cnt", int'(cnt_out), 7);

    // Randomized jobs with occasional aborts.
    for (int k = 0; k < 30; k++) begin
      int r;
      int w;
      int n;
      int ab;
      r          = $urandom_range(1, 3);
      req_mode   = 2'($urandom_range(0, 3));
      req_steps0 = 4'($urandom_range(0, 15));
      req_steps1 = 4'($urandom_range(0, 15));
      req        = req | 2'(r);
      w  = pick();
      n  = (w == 1) ? int'(req_steps1) : int'(req_steps0);
      ab = -1;
      if (n > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(0, n - 1);
      serve(w, ab);
    end
    while (req != 2'b00) serve(pick(), -1);

    // Reset during a 5-step job.
    req_mode[0] = 1'b1;
    req_steps0  = 4'd5;
    req         = 2'b01;
    @(negedge clk);
    chk("rst_job_grant", int'(grant), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    req = 2'b00;
    @(negedge clk);
    chk("midrst_cnt", int'(cnt_out), 0);
    chk("midrst_grant", int'(grant), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_owner", int'(owner), 0);
    rst = 1'b0;
    model_cnt = 0;
    model_rr  = 0;
    @(negedge clk);

    // After reset requester 0 has priority again.
    req_mode   = 2'b10;
    req_steps0 = 4'd1;
    req_steps1 = 4'd1;
    req        = 2'b11;
    serve(pick(), -1);
    serve(pick(), -1);
    chk("post_rst_cnt", int'(cnt_out), 0);

    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
